decode_stage: RTL
=================

Name: decode_stage

Overview:
Registered RV32I/M instruction decode stage. It sits between the fetch/IF-ID register and execute. It decodes a fetched instruction into control_pkg control fields, flags illegal encodings, and interlocks load-use hazards by inserting exactly one bubble. Fetch and execute connect through a valid/ready handshake, so a downstream stall back-pressures fetch without losing instructions.

Parameters:
XLEN, 32, width of the PC path.
ENABLE_M, 1, when 1, decode RV32M (funct7=0000001 on OP_R_TYPE); when 0, those encodings are illegal.
ENABLE_HAZARD, 1, when 0, the load-use bubble logic is removed and bub is held at 0.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
flush  in  1  squash the held entry; no capture this cycle.
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  stage can accept this cycle.
in_instr  in  32  instruction word.
in_pc  in  XLEN  PC of in_instr.
out_valid  out  1  decoded entry is presented to execute.
out_ready  in  1  execute accepts.
out_pc  out  XLEN  captured PC.
out_alu_op  out  alu_op_e  ALU operation; control_pkg extended with ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
out_regwen, out_imm_sel, out_a_sel, out_b_sel, out_wb_sel, out_branch_type  out  control_pkg types  decoded controls.
out_rs1, out_rs2, out_rd  out  5 each  register indices.
out_mem_funct3  out  3  instr[14:12] for loads/stores, else 0.
out_is_load  out  1  entry is OP_LOAD.
out_illegal  out  1  entry is an illegal encoding.

Behaviour:
- Decode per opcode:
  - R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM and FENCE decode as the existing RV32I control mapping.
  - JAL: alu_op = ALU_ADD.
  - RV32M, funct3 000..111 maps to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, with regwen=1.
- Illegal encodings (out_illegal=1):
  - instr[1:0] != 11 or an unknown opcode.
  - R-type: funct7 not in {0000000, 0100000 with funct3 000/101, 0000001 with ENABLE_M=1}.
  - SLLI with funct7 != 0.
  - SRLI/SRAI with funct7 not in {0000000, 0100000}.
  - LOAD funct3 in {011, 110, 111}.
  - STORE funct3 > 010.
  - BRANCH funct3 in {010, 011}.
  - JALR funct3 != 000.
- For an illegal entry: regwen=0, branch_type=BR_NONE, out_is_load=0; the other fields are don't-care.
- Register usage:
  - uses_rs1 for R, I, LOAD, STORE, BRANCH, JALR.
  - uses_rs2 for R, STORE, BRANCH.
- Internal state: v (entry held), bub (bubble pending), plus the captured decode.
- Handshake:
  - out_valid = v & ~bub.
  - fire = out_valid & out_ready.
  - in_ready = ~v | fire.
  - accept = in_valid & in_ready & ~flush.
- Next-state, in priority order:
  - ~rst_n: v=0, bub=0, all outputs 0 (out_alu_op=ALU_ADD, enums at their defaults, out_pc=0).
  - flush: v=0, bub=0. This holds even if fire occurs the same cycle, since execute has already taken that entry.
  - accept: v=1, capture the decode and the PC.
    - bub = ENABLE_HAZARD & fire & out_is_load & out_rd != 0 & ((uses_rs1(new) & rs1 == out_rd) | (uses_rs2(new) & rs2 == out_rd)).
  - else if fire: v=0.
  - else if bub: bub=0.
- Latency: 1 cycle from accept to out_valid when there is no hazard, 2 cycles with a hazard.
- Throughput is 1 per cycle while out_ready=1.
- Stall rule: outputs are stable while out_valid & ~out_ready.
- During a bubble, in_ready=0 and the entry is held (out_valid=0).
- A load with rd=x0 never triggers a bubble.
- A non-load producer never triggers a bubble; forwarding covers it.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, out_regwen=0. One cycle after release, in_ready=1.
- Stream ADD x3,x1,x2 (0x002081B3) then SUB x4,x3,x1 (0x40118233) with out_ready=1 -> ALU_ADD then ALU_SUB on consecutive cycles, no bubble.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x2 (0x00228333) -> LW issues at t, out_valid=0 at t+1, ADD issues at t+2. Repeat with ENABLE_HAZARD=0 -> no gap.
- MUL x7,x1,x2 (0x022083B3) -> ENABLE_M=1: ALU_MUL, regwen=1. ENABLE_M=0: out_illegal=1, regwen=0.
- Hold out_ready=0 for 3 cycles with a valid entry -> outputs stable, in_ready=0. Asserting flush -> out_valid=0 next cycle, and the pending input is not captured.
- Encodings 0x0000B003 (LD), 0xFFFFFFFF and 0x00001067 (JALR funct3=1) -> out_illegal=1, branch_type=BR_NONE.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/M decode stage: decodes a fetched instruction into registered control
// fields, flags illegal encodings and inserts one bubble on a load-use hazard.
// Fetch and execute are coupled by a valid/ready handshake.

package control_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [2:0] { IMM_I, IMM_S, IMM_B, IMM_U, IMM_J } imm_sel_e;
    typedef enum logic [1:0] { A_RS1, A_PC, A_ZERO } a_sel_e;
    typedef enum logic       { B_RS2, B_IMM } b_sel_e;
    typedef enum logic [1:0] { WB_ALU, WB_MEM, WB_PC4 } wb_sel_e;

    typedef enum logic [3:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JAL, BR_JALR
    } branch_type_e;

endpackage

module decode_stage
    import control_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ENABLE_M      = 1,
    parameter int unsigned ENABLE_HAZARD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output alu_op_e         out_alu_op,
    output logic            out_regwen,
    output imm_sel_e        out_imm_sel,
    output a_sel_e          out_a_sel,
    output b_sel_e          out_b_sel,
    output wb_sel_e         out_wb_sel,
    output branch_type_e    out_branch_type,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_mem_funct3,
    output logic            out_is_load,
    output logic            out_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    alu_op_e      d_alu_op;
    logic         d_regwen;
    imm_sel_e     d_imm_sel;
    a_sel_e       d_a_sel;
    b_sel_e       d_b_sel;
    wb_sel_e      d_wb_sel;
    branch_type_e d_branch_type;
    logic [2:0]   d_mem_funct3;
    logic         d_is_load;
    logic         d_illegal;
    logic         d_uses_rs1;
    logic         d_uses_rs2;

    logic v;
    logic bub;
    logic fire;
    logic accept;
    logic hazard;

    // Base integer ALU op selected by funct3 (funct7 variants handled by the caller)
    function automatic alu_op_e alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Combinational decode of the presented instruction
    always_comb begin
        d_alu_op      = ALU_ADD;
        d_regwen      = 1'b0;
        d_imm_sel     = IMM_I;
        d_a_sel       = A_RS1;
        d_b_sel       = B_RS2;
        d_wb_sel      = WB_ALU;
        d_branch_type = BR_NONE;
        d_mem_funct3  = 3'b000;
        d_is_load     = 1'b0;
        d_illegal     = (in_instr[1:0] != 2'b11);
        d_uses_rs1    = 1'b0;
        d_uses_rs2    = 1'b0;

        case (opcode)
            OP_R_TYPE: begin
                d_uses_rs1 = 1'b1;
                d_uses_rs2 = 1'b1;
                d_regwen   = 1'b1;
                case (funct7)
                    7'b0000000: d_alu_op = alu_base(funct3);
                    7'b0100000: begin
                        if (funct3 == 3'b000)      d_alu_op = ALU_SUB;
                        else if (funct3 == 3'b101) d_alu_op = ALU_SRA;
                        else                       d_illegal = 1'b1;
                    end
                    7'b0000001: begin
                        if (ENABLE_M != 0) begin
                            case (funct3)
                                3'b000:  d_alu_op = ALU_MUL;
                                3'b001:  d_alu_op = ALU_MULH;
                                3'b010:  d_alu_op = ALU_MULHSU;
                                3'b011:  d_alu_op = ALU_MULHU;
                                3'b100:  d_alu_op = ALU_DIV;
                                3'b101:  d_alu_op = ALU_DIVU;
                                3'b110:  d_alu_op = ALU_REM;
                                default: d_alu_op = ALU_REMU;
                            endcase
                        end else begin
                            d_illegal = 1'b1;
                        end
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                d_uses_rs1 = 1'b1;
                d_regwen   = 1'b1;
                d_b_sel    = B_IMM;
                d_alu_op   = alu_base(funct3);
                if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
                    d_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000)      d_alu_op = ALU_SRA;
                    else if (funct7 != 7'b0000000) d_illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                d_uses_rs1   = 1'b1;
                d_regwen     = 1'b1;
                d_b_sel      = B_IMM;
                d_wb_sel     = WB_MEM;
                d_is_load    = 1'b1;
                d_mem_funct3 = funct3;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) d_illegal = 1'b1;
            end
            OP_STORE: begin
                d_uses_rs1   = 1'b1;
                d_uses_rs2   = 1'b1;
                d_imm_sel    = IMM_S;
                d_b_sel      = B_IMM;
                d_mem_funct3 = funct3;
                if (funct3 > 3'b010) d_illegal = 1'b1;
            end
            OP_BRANCH: begin
                d_uses_rs1 = 1'b1;
                d_uses_rs2 = 1'b1;
                d_imm_sel  = IMM_B;
                d_a_sel    = A_PC;
                d_b_sel    = B_IMM;
                case (funct3)
                    3'b000:  d_branch_type = BR_EQ;
                    3'b001:  d_branch_type = BR_NE;
                    3'b100:  d_branch_type = BR_LT;
                    3'b101:  d_branch_type = BR_GE;
                    3'b110:  d_branch_type = BR_LTU;
                    3'b111:  d_branch_type = BR_GEU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                d_regwen      = 1'b1;
                d_imm_sel     = IMM_J;
                d_a_sel       = A_PC;
                d_b_sel       = B_IMM;
                d_wb_sel      = WB_PC4;
                d_branch_type = BR_JAL;
            end
            OP_JALR: begin
                d_uses_rs1    = 1'b1;
                d_regwen      = 1'b1;
                d_b_sel       = B_IMM;
                d_wb_sel      = WB_PC4;
                d_branch_type = BR_JALR;
                if (funct3 != 3'b000) d_illegal = 1'b1;
            end
            OP_LUI: begin
                d_regwen  = 1'b1;
                d_imm_sel = IMM_U;
                d_a_sel   = A_ZERO;
                d_b_sel   = B_IMM;
            end
            OP_AUIPC: begin
                d_regwen  = 1'b1;
                d_imm_sel = IMM_U;
                d_a_sel   = A_PC;
                d_b_sel   = B_IMM;
            end
            OP_SYSTEM, OP_FENCE: begin
            end
            default: d_illegal = 1'b1;
        endcase

        if (d_illegal) begin
            d_regwen      = 1'b0;
            d_branch_type = BR_NONE;
            d_is_load     = 1'b0;
        end
    end

    assign out_valid = v & ~bub;
    assign fire      = out_valid & out_ready;
    assign in_ready  = ~v | fire;
    assign accept    = in_valid & in_ready & ~flush;

    // The load being retired this cycle is compared against the incoming consumer
    assign hazard = (ENABLE_HAZARD != 0) && fire && out_is_load && (out_rd != 5'd0) &&
                    ((d_uses_rs1 && (in_instr[19:15] == out_rd)) ||
                     (d_uses_rs2 && (in_instr[24:20] == out_rd)));

    // Holding register and handshake state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v               <= 1'b0;
            bub             <= 1'b0;
            out_pc          <= '0;
            out_alu_op      <= ALU_ADD;
            out_regwen      <= 1'b0;
            out_imm_sel     <= IMM_I;
            out_a_sel       <= A_RS1;
            out_b_sel       <= B_RS2;
            out_wb_sel      <= WB_ALU;
            out_branch_type <= BR_NONE;
            out_rs1         <= '0;
            out_rs2         <= '0;
            out_rd          <= '0;
            out_mem_funct3  <= '0;
            out_is_load     <= 1'b0;
            out_illegal     <= 1'b0;
        end else if (flush) begin
            v   <= 1'b0;
            bub <= 1'b0;
        end else if (accept) begin
            v               <= 1'b1;
            bub             <= hazard;
            out_pc          <= in_pc;
            out_alu_op      <= d_alu_op;
            out_regwen      <= d_regwen;
            out_imm_sel     <= d_imm_sel;
            out_a_sel       <= d_a_sel;
            out_b_sel       <= d_b_sel;
            out_wb_sel      <= d_wb_sel;
            out_branch_type <= d_branch_type;
            out_rs1         <= in_instr[19:15];
            out_rs2         <= in_instr[24:20];
            out_rd          <= in_instr[11:7];
            out_mem_funct3  <= d_mem_funct3;
            out_is_load     <= d_is_load;
            out_illegal     <= d_illegal;
        end else if (fire) begin
            v <= 1'b0;
        end else if (bub) begin
            bub <= 1'b0;
        end
    end

endmodule
